// File: rtl/spm_bank_pkg.sv
// Shared types, defaults and helpers for the scratchpad bank model.
package spm_bank_pkg;

    localparam int SPM_DEF_NUM_WORDS      = 1024;
    localparam int SPM_DEF_DATA_WIDTH     = 32;
    localparam int SPM_DEF_RESP_LAT       = 1;
    localparam int SPM_DEF_REFRESH_PERIOD = 0;
    localparam int SPM_DEF_REFRESH_CYCLES = 4;
    localparam int SPM_DEF_CNT_WIDTH      = 32;

    // Counters are held at this width; the configured CNT_WIDTH only sets the saturation point.
    localparam int SPM_STAT_MAX_W = 64;

    typedef enum logic {
        IDLE    = 1'b0,
        REFRESH = 1'b1
    } refresh_state_e;

    typedef struct packed {
        logic [SPM_STAT_MAX_W-1:0] rd;
        logic [SPM_STAT_MAX_W-1:0] wr;
        logic [SPM_STAT_MAX_W-1:0] stall;
    } spm_bank_stats_t;

    // Clear beats increment; increments stop at max.
    function automatic logic [SPM_STAT_MAX_W-1:0] stat_next(
        input logic [SPM_STAT_MAX_W-1:0] cnt,
        input logic                      inc,
        input logic                      clr,
        input logic [SPM_STAT_MAX_W-1:0] max
    );
        if (clr) return '0;
        if (inc && (cnt != max)) return cnt + SPM_STAT_MAX_W'(1);
        return cnt;
    endfunction

endpackage

// File: rtl/spm_bank_model_if.sv
// TCDM-style req/gnt bank port: master issues requests, slave grants and responds.
interface spm_bank_model_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
);
    logic                    req;
    logic                    gnt;
    logic [ADDR_WIDTH-1:0]   add;
    logic                    wen;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] be;
    logic [DATA_WIDTH-1:0]   rdata;
    logic                    rvalid;

    modport master (
        output req, add, wen, wdata, be,
        input  gnt, rdata, rvalid
    );

    modport slave (
        input  req, add, wen, wdata, be,
        output gnt, rdata, rvalid
    );
endinterface

// File: rtl/spm_bank_refresh_ctrl.sv
// Free-running period counter plus IDLE/REFRESH FSM that raises busy_o for a fixed
// blackout window at strictly periodic starts. REFRESH_PERIOD=0 keeps it idle forever.
module spm_bank_refresh_ctrl
    import spm_bank_pkg::*;
#(
    parameter int REFRESH_PERIOD = SPM_DEF_REFRESH_PERIOD,
    parameter int REFRESH_CYCLES = SPM_DEF_REFRESH_CYCLES
) (
    input  logic clk_i,
    input  logic rst_ni,
    output logic busy_o
);

    localparam int PW = (REFRESH_PERIOD > 1) ? $clog2(REFRESH_PERIOD) : 1;
    localparam int CW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam bit EN = (REFRESH_PERIOD > 0);
    localparam logic [PW-1:0] PER_TC = PW'((REFRESH_PERIOD > 0) ? REFRESH_PERIOD - 1 : 0);
    localparam logic [CW-1:0] REF_TC = CW'((REFRESH_CYCLES > 0) ? REFRESH_CYCLES - 1 : 0);

    refresh_state_e r_state;
    logic [PW-1:0]  r_per_cnt;
    logic [CW-1:0]  r_ref_cnt;
    logic           r_busy;

    // Period counter never pauses, so the blackout length does not skew the period.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= IDLE;
            r_per_cnt <= '0;
            r_ref_cnt <= '0;
            r_busy    <= 1'b0;
        end else if (EN) begin
            r_per_cnt <= (r_per_cnt == PER_TC) ? '0 : r_per_cnt + PW'(1);
            case (r_state)
                IDLE: begin
                    if (r_per_cnt == PER_TC) begin
                        r_state   <= REFRESH;
                        r_busy    <= 1'b1;
                        r_ref_cnt <= '0;
                    end
                end
                REFRESH: begin
                    if (r_ref_cnt == REF_TC) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_ref_cnt <= r_ref_cnt + CW'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o = r_busy;

endmodule

// File: rtl/spm_bank_model.sv
// Behavioural single-port scratchpad bank: byte-masked array, RESP_LAT-deep response
// pipeline and refresh blackouts. Statistics counters exist only with SPM_BANK_STATS_EN.
module spm_bank_model
    import spm_bank_pkg::*;
#(
    parameter int NUM_WORDS      = SPM_DEF_NUM_WORDS,
    parameter int DATA_WIDTH     = SPM_DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH     = $clog2(NUM_WORDS),
    parameter int RESP_LAT       = SPM_DEF_RESP_LAT,
    parameter int REFRESH_PERIOD = SPM_DEF_REFRESH_PERIOD,
    parameter int REFRESH_CYCLES = SPM_DEF_REFRESH_CYCLES,
    parameter int CNT_WIDTH      = SPM_DEF_CNT_WIDTH
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    spm_bank_model_if.slave      tcdm,
    output logic                 busy_o,
    input  logic                 stat_clr_i,
    output logic [CNT_WIDTH-1:0] stat_rd_o,
    output logic [CNT_WIDTH-1:0] stat_wr_o,
    output logic [CNT_WIDTH-1:0] stat_stall_o
);

    localparam int BE_W = DATA_WIDTH / 8;
    localparam int IW   = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

    logic [ADDR_WIDTH-1:0] w_add;
    logic [IW-1:0]         w_idx;
    logic                  w_busy;
    logic                  w_gnt;
    logic                  w_rd_acc;
    logic                  w_wr_acc;
    logic                  w_stall;
    logic [DATA_WIDTH-1:0] w_rword;

    logic [DATA_WIDTH-1:0]             r_mem [NUM_WORDS];
    logic [RESP_LAT:1]                 r_vld_pipe;
    logic [RESP_LAT:1]                 r_rd_pipe;
    logic [RESP_LAT:1][DATA_WIDTH-1:0] r_dat_pipe;

    spm_bank_refresh_ctrl #(
        .REFRESH_PERIOD (REFRESH_PERIOD),
        .REFRESH_CYCLES (REFRESH_CYCLES)
    ) u_refresh (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .busy_o (w_busy)
    );

    // Addresses beyond the array depth alias back into it.
    assign w_add    = tcdm.add;
    assign w_idx    = IW'(32'(w_add) % 32'(NUM_WORDS));
    assign w_gnt    = tcdm.req & ~w_busy;
    assign w_rd_acc = w_gnt & tcdm.wen;
    assign w_wr_acc = w_gnt & ~tcdm.wen;
    assign w_stall  = tcdm.req & ~w_gnt;
    assign w_rword  = r_mem[w_idx];

    // Array content is deliberately left out of reset.
    always_ff @(posedge clk_i) begin
        if (w_wr_acc) begin
            for (int b = 0; b < BE_W; b++) begin
                if (tcdm.be[b]) r_mem[w_idx][8*b +: 8] <= tcdm.wdata[8*b +: 8];
            end
        end
    end

    // Last stage doubles as the output register; data only moves for reads so rdata holds.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_vld_pipe <= '0;
            r_rd_pipe  <= '0;
            r_dat_pipe <= '0;
        end else begin
            r_vld_pipe[1] <= w_gnt;
            r_rd_pipe[1]  <= w_rd_acc;
            if (w_rd_acc) r_dat_pipe[1] <= w_rword;
            for (int k = 2; k <= RESP_LAT; k++) begin
                r_vld_pipe[k] <= r_vld_pipe[k-1];
                r_rd_pipe[k]  <= r_rd_pipe[k-1];
                if (r_rd_pipe[k-1]) r_dat_pipe[k] <= r_dat_pipe[k-1];
            end
        end
    end

    assign tcdm.gnt    = w_gnt;
    assign tcdm.rvalid = r_vld_pipe[RESP_LAT];
    assign tcdm.rdata  = r_dat_pipe[RESP_LAT];
    assign busy_o      = w_busy;

`ifdef SPM_BANK_STATS_EN
    localparam logic [SPM_STAT_MAX_W-1:0] CNT_MAX = (CNT_WIDTH >= SPM_STAT_MAX_W) ? '1 :
        ((SPM_STAT_MAX_W'(1) << CNT_WIDTH) - SPM_STAT_MAX_W'(1));

    spm_bank_stats_t r_stats;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_stats <= '0;
        end else begin
            r_stats.rd    <= stat_next(r_stats.rd,    w_rd_acc, stat_clr_i, CNT_MAX);
            r_stats.wr    <= stat_next(r_stats.wr,    w_wr_acc, stat_clr_i, CNT_MAX);
            r_stats.stall <= stat_next(r_stats.stall, w_stall,  stat_clr_i, CNT_MAX);
        end
    end

    assign stat_rd_o    = r_stats.rd[CNT_WIDTH-1:0];
    assign stat_wr_o    = r_stats.wr[CNT_WIDTH-1:0];
    assign stat_stall_o = r_stats.stall[CNT_WIDTH-1:0];
`else
    logic w_unused_stats;
    assign w_unused_stats = stat_clr_i ^ w_stall;
    assign stat_rd_o      = '0;
    assign stat_wr_o      = '0;
    assign stat_stall_o   = '0;
`endif

endmodule

// File: tb/tb_spm_bank_model.sv
// Directed bench: bank A (RESP_LAT=3, 1000 words, no refresh) scoreboarded against a
// memory model; bank B (RESP_LAT=2, refresh 20/4) checked cycle by cycle for blackouts.
module tb_spm_bank_model;

`ifdef SPM_BANK_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    localparam int A_WORDS = 1000;
    localparam int A_LAT   = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    spm_bank_model_if #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) bus_a ();
    spm_bank_model_if #(.ADDR_WIDTH(6),  .DATA_WIDTH(32)) bus_b ();

    logic       busy_a, busy_b, clr_a, clr_b;
    logic [2:0] rd_a, wr_a, st_a;
    logic [3:0] rd_b, wr_b, st_b;

    spm_bank_model #(
        .NUM_WORDS(A_WORDS), .DATA_WIDTH(32), .ADDR_WIDTH(10), .RESP_LAT(A_LAT),
        .REFRESH_PERIOD(0), .REFRESH_CYCLES(4), .CNT_WIDTH(3)
    ) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .tcdm(bus_a), .busy_o(busy_a), .stat_clr_i(clr_a),
        .stat_rd_o(rd_a), .stat_wr_o(wr_a), .stat_stall_o(st_a)
    );

    spm_bank_model #(
        .NUM_WORDS(64), .DATA_WIDTH(32), .ADDR_WIDTH(6), .RESP_LAT(2),
        .REFRESH_PERIOD(20), .REFRESH_CYCLES(4), .CNT_WIDTH(4)
    ) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .tcdm(bus_b), .busy_o(busy_b), .stat_clr_i(clr_b),
        .stat_rd_o(rd_b), .stat_wr_o(wr_b), .stat_stall_o(st_b)
    );

    typedef struct {
        logic        rd;
        logic [31:0] data;
        int          due;
    } sb_t;

    sb_t         sb[$];
    logic [31:0] mem_m [A_WORDS];
    logic [31:0] last_rd;
    int          cyc;
    int          n_vec = 0;
    int          n_err = 0;
    int          exp_rd, exp_wr;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; any bank-A response is matched against the scoreboard head.
    task automatic tick();
        sb_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (bus_a.rvalid) begin
            if (sb.size() == 0) begin
                chk("a_rvalid_spurious", 64'(bus_a.rvalid), 64'd0);
            end else begin
                e = sb.pop_front();
                chk("a_rvalid_cycle", 64'(cyc), 64'(e.due));
                if (e.rd) begin
                    chk("a_rdata", 64'(bus_a.rdata), 64'(e.data));
                    last_rd = e.data;
                end else begin
                    chk("a_rdata_hold", 64'(bus_a.rdata), 64'(last_rd));
                end
            end
        end else if (sb.size() != 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            chk("a_rvalid_missing", 64'(bus_a.rvalid), 64'd1);
        end
    endtask

    task automatic a_drive(input logic rd, input int addr, input logic [31:0] d, input logic [3:0] be);
        int idx;
        sb_t e;
        bus_a.req = 1'b1; bus_a.wen = rd; bus_a.add = 10'(addr);
        bus_a.wdata = d; bus_a.be = be;
        #1 chk("a_gnt", 64'(bus_a.gnt), 64'd1);
        idx = addr % A_WORDS;
        e.rd = rd; e.data = '0; e.due = cyc + A_LAT;
        if (rd) begin
            e.data = mem_m[idx];
            exp_rd = (exp_rd == 7) ? 7 : exp_rd + 1;
        end else begin
            for (int b = 0; b < 4; b++) if (be[b]) mem_m[idx][8*b +: 8] = d[8*b +: 8];
            exp_wr = (exp_wr == 7) ? 7 : exp_wr + 1;
        end
        sb.push_back(e);
        tick();
    endtask

    task automatic a_drain();
        bus_a.req = 1'b0;
        for (int i = 0; i < 10 && sb.size() != 0; i++) tick();
        chk("a_sb_empty", 64'(sb.size()), 64'd0);
    endtask

    task automatic chk_stats_a(input string tag, input int r, input int w);
        chk({tag, "_rd"},    64'(rd_a), STATS ? 64'(r) : 64'd0);
        chk({tag, "_wr"},    64'(wr_a), STATS ? 64'(w) : 64'd0);
        chk({tag, "_stall"}, 64'(st_a), 64'd0);
    endtask

    task automatic chk_reset_vals();
        chk("rst_a_rvalid", 64'(bus_a.rvalid), 64'd0);
        chk("rst_a_rdata",  64'(bus_a.rdata),  64'd0);
        chk("rst_b_rvalid", 64'(bus_b.rvalid), 64'd0);
        chk("rst_b_rdata",  64'(bus_b.rdata),  64'd0);
        chk("rst_b_busy",   64'(busy_b),       64'd0);
        chk("rst_b_stats",  64'({rd_b, wr_b, st_b}), 64'd0);
        chk_stats_a("rst_a", 0, 0);
    endtask

    // Async reset, then release just after an edge so cycle 0 starts with cyc = 0.
    task automatic do_reset();
        rst_n = 1'b0;
        bus_a.req = 1'b0; bus_b.req = 1'b0;
        #1 chk_reset_vals();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc = 0;
        sb.delete();
        last_rd = '0; exp_rd = 0; exp_wr = 0;
    endtask

    initial begin
        bus_a.req = 1'b0; bus_a.wen = 1'b1; bus_a.add = '0; bus_a.wdata = '0; bus_a.be = '0;
        bus_b.req = 1'b0; bus_b.wen = 1'b1; bus_b.add = '0; bus_b.wdata = '0; bus_b.be = '0;
        clr_a = 1'b0; clr_b = 1'b0;
        cyc = 0; last_rd = '0; exp_rd = 0; exp_wr = 0;

        // Reset values and combinational grant while held in reset.
        #1 chk_reset_vals();
        bus_b.req = 1'b1;
        #1 chk("rst_b_gnt_hi", 64'(bus_b.gnt), 64'd1);
        bus_b.req = 1'b0;
        #1 chk("rst_b_gnt_lo", 64'(bus_b.gnt), 64'd0);
        do_reset();

        // Bank B: req held high, blackouts in cycles 20-23 and 40-43.
        for (int c = 0; c <= 44; c++) begin
            bus_b.req = 1'b1; bus_b.wen = 1'b1; bus_b.add = '0;
            #1;
            chk($sformatf("b_gnt_c%0d", c), 64'(bus_b.gnt),
                64'(!((c >= 20 && c <= 23) || (c >= 40 && c <= 43))));
            chk($sformatf("b_busy_c%0d", c), 64'(busy_b),
                64'((c >= 20 && c <= 23) || (c >= 40 && c <= 43)));
            if (c == 44) chk("b_stall_44", 64'(st_b), STATS ? 64'd8 : 64'd0);
            tick();
        end
        bus_b.req = 1'b0;

        // Bank A: byte-masked merge, burst writes/reads, write-then-read, address wrap.
        a_drive(1'b0, 5, 32'hDEADBEEF, 4'hF);
        a_drive(1'b0, 5, 32'h000000AA, 4'h1);
        a_drive(1'b1, 5, '0, 4'h0);
        bus_a.req = 1'b0; tick(); tick();
        for (int i = 0; i < 8; i++) a_drive(1'b0, i, 32'h1000_0000 + 32'(i) * 32'h0111_1111, 4'hF);
        for (int i = 0; i < 8; i++) a_drive(1'b1, i, '0, 4'h0);
        a_drive(1'b0, 20, 32'h5555_AAAA, 4'hF);
        a_drive(1'b1, 20, '0, 4'h0);
        a_drive(1'b1, 1005, '0, 4'h0);
        a_drive(1'b0, 999, 32'h1234_5678, 4'hF);
        a_drive(1'b0, 999, 32'hABCD_0000, 4'hC);
        a_drive(1'b1, 999, '0, 4'h0);
        a_drain();
        chk_stats_a("a_sat", exp_rd, exp_wr);

        // Reset with two reads in flight: nothing may come out afterwards.
        a_drive(1'b1, 0, '0, 4'h0);
        a_drive(1'b1, 1, '0, 4'h0);
        do_reset();

        // Bank B: write at 5, read accepted at 19 completes at 21 inside the blackout.
        for (int c = 0; c <= 23; c++) begin
            bus_b.req = (c == 5 || c == 19); bus_b.wen = (c != 5);
            bus_b.add = 6'd3; bus_b.wdata = 32'hCAFE_F00D; bus_b.be = 4'hF;
            #1;
            if (c < 8) begin
                chk("a_post_rst_rvalid", 64'(bus_a.rvalid), 64'd0);
                chk("a_post_rst_rdata",  64'(bus_a.rdata),  64'd0);
            end
            chk($sformatf("b_rvalid_c%0d", c), 64'(bus_b.rvalid), 64'(c == 7 || c == 21));
            if (c == 7)  chk("b_rdata_hold_wr", 64'(bus_b.rdata), 64'd0);
            if (c == 21) begin
                chk("b_rdata_blackout", 64'(bus_b.rdata), 64'hCAFE_F00D);
                chk("b_busy_21", 64'(busy_b), 64'd1);
            end
            tick();
        end
        bus_b.req = 1'b0;

        // Bank A stats: 2 writes, 3 reads, then clear coinciding with a read accept.
        a_drive(1'b0, 40, 32'h0404_0404, 4'hF);
        a_drive(1'b0, 41, 32'h0414_1414, 4'hF);
        a_drive(1'b1, 40, '0, 4'h0);
        a_drive(1'b1, 41, '0, 4'h0);
        a_drive(1'b1, 40, '0, 4'h0);
        chk_stats_a("a_pre_clr", 3, 2);
        clr_a = 1'b1;
        a_drive(1'b1, 41, '0, 4'h0);
        clr_a = 1'b0;
        chk_stats_a("a_post_clr", 0, 0);
        a_drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
